fifo_ctrl_reg: RTL and testbench

Sequential control stage of the 8-entry FIFO. It holds the FSM state register and the head, tail and data_count registers. The current values feed the combinational pointer/count calculator, and that calculator's next_head/next_tail/next_data_count come back into this block. It also decodes the registered state into status and handshake flags for the FIFO top and the DMAC.

---
 rtl/fifo_defs_pkg.sv | 26 ++
 rtl/fifo_ns.sv | 34 +++
 rtl/fifo_ctrl_reg.sv | 80 ++++++++
 tb/tb_fifo_ctrl_reg.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fifo_defs
//  Description : Shared definitions for the 8-entry FIFO control stage:
//                geometry constants and the FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_defs;

  localparam int DEPTH  = 8;   // number of FIFO entries
  localparam int ADDR_W = 3;   // head/tail pointer width
  localparam int CNT_W  = 4;   // occupancy width, holds 0..DEPTH

  // Codes 3'b110 and 3'b111 are unused; the next-state logic does not
  // depend on the current state, so an illegal code clears in one cycle.
  typedef enum logic [2:0] {
    ST_INIT   = 3'b000,
    ST_NO_OP  = 3'b001,
    ST_WRITE  = 3'b010,
    ST_WR_ERR = 3'b011,
    ST_READ   = 3'b100,
    ST_RD_ERR = 3'b101
  } state_t;

endpackage : fifo_defs
`default_nettype wire

// File: rtl/fifo_ns.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ns
//  Description : Next-state decision for the FIFO control FSM. Purely
//                combinational.
//  Ports       : wr_en           - write request this cycle
//                rd_en           - read request this cycle
//                next_data_count - occupancy committed at the coming edge
//                ns              - next FSM state
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ns
  import fifo_defs::*;
(
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [CNT_W-1:0] next_data_count,
  output state_t           ns
);

  // next_data_count already includes the effect of the transfer that is
  // completing at this edge, so back-to-back requests see the real
  // occupancy rather than a stale one.
  always_comb begin
    ns = ST_NO_OP;
    if (wr_en && !rd_en) begin
      ns = (next_data_count == CNT_W'(DEPTH)) ? ST_WR_ERR : ST_WRITE;
    end else if (rd_en && !wr_en) begin
      ns = (next_data_count == '0) ? ST_RD_ERR : ST_READ;
    end
  end

endmodule : fifo_ns
`default_nettype wire

// File: rtl/fifo_ctrl_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ctrl_reg
//  Description : Sequential control stage of the 8-entry FIFO. Holds the FSM
//                state, head, tail and data_count registers, takes the next
//                pointer/count values from the external calculator, and
//                decodes status/handshake flags from the registered values.
//  Ports       : clk, reset_n (async, active-low)
//                wr_en, rd_en                      - requests
//                next_head/next_tail/next_data_count - from calculator
//                state/head/tail/data_count         - registered values
//                full, empty                        - occupancy status
//                wr_ack, wr_err, rd_ack, rd_err     - handshake flags
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl_reg
  import fifo_defs::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] next_head,
  input  logic [ADDR_W-1:0] next_tail,
  input  logic [CNT_W-1:0]  next_data_count,
  output logic [2:0]        state,
  output logic [ADDR_W-1:0] head,
  output logic [ADDR_W-1:0] tail,
  output logic [CNT_W-1:0]  data_count,
  output logic              full,
  output logic              empty,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err
);

  state_t            state_q;
  state_t            ns;
  logic [ADDR_W-1:0] head_q;
  logic [ADDR_W-1:0] tail_q;
  logic [CNT_W-1:0]  count_q;

  fifo_ns u_fifo_ns (
    .wr_en           (wr_en),
    .rd_en           (rd_en),
    .next_data_count (next_data_count),
    .ns              (ns)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= ns;
      head_q  <= next_head;
      tail_q  <= next_tail;
      count_q <= next_data_count;
    end
  end

  assign state      = state_q;
  assign head       = head_q;
  assign tail       = tail_q;
  assign data_count = count_q;

  // Flags decode only registered values, so no request input reaches an
  // output combinationally.
  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_ack = (state_q == ST_WRITE);
  assign wr_err = (state_q == ST_WR_ERR);
  assign rd_ack = (state_q == ST_READ);
  assign rd_err = (state_q == ST_RD_ERR);

endmodule : fifo_ctrl_reg
`default_nettype wire

// File: tb/tb_fifo_ctrl_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_ctrl_reg
//  Description : Self-checking bench for fifo_ctrl_reg. A behavioural
//                pointer/count calculator closes the loop around the DUT; a
//                reference model predicts the registered values after each
//                edge and pushes them to a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl_reg;
  import fifo_defs::*;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] hd;
    logic [2:0] tl;
    logic [3:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en, rd_en;
  logic [2:0] next_head, next_tail;
  logic [3:0] next_data_count;
  logic [2:0] state, head, tail;
  logic [3:0] data_count;
  logic       full, empty, wr_ack, wr_err, rd_ack, rd_err;

  int n_vec = 0;
  int n_err = 0;

  exp_t sb_q[$];

  // reference model registers
  logic [2:0] m_st, m_hd, m_tl;
  logic [3:0] m_cnt;

  always #5 clk = ~clk;

  fifo_ctrl_reg dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .wr_en           (wr_en),
    .rd_en           (rd_en),
    .next_head       (next_head),
    .next_tail       (next_tail),
    .next_data_count (next_data_count),
    .state           (state),
    .head            (head),
    .tail            (tail),
    .data_count      (data_count),
    .full            (full),
    .empty           (empty),
    .wr_ack          (wr_ack),
    .wr_err          (wr_err),
    .rd_ack          (rd_ack),
    .rd_err          (rd_err)
  );

  // Behavioural pointer/count calculator: acts on the registered state.
  always_comb begin
    next_head       = head;
    next_tail       = tail;
    next_data_count = data_count;
    case (state)
      3'b010: begin next_tail = tail + 3'd1; next_data_count = data_count + 4'd1; end
      3'b100: begin next_head = head + 3'd1; next_data_count = data_count - 4'd1; end
      3'b011: next_data_count = 4'd8;
      3'b101: next_data_count = 4'd0;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input exp_t e);
    check("state",  32'(state),      32'(e.st));
    check("head",   32'(head),       32'(e.hd));
    check("tail",   32'(tail),       32'(e.tl));
    check("count",  32'(data_count), 32'(e.cnt));
    check("full",   32'(full),       32'(e.cnt == 4'd8));
    check("empty",  32'(empty),      32'(e.cnt == 4'd0));
    check("wr_ack", 32'(wr_ack),     32'(e.st == 3'b010));
    check("wr_err", 32'(wr_err),     32'(e.st == 3'b011));
    check("rd_ack", 32'(rd_ack),     32'(e.st == 3'b100));
    check("rd_err", 32'(rd_err),     32'(e.st == 3'b101));
  endtask

  task automatic model_reset();
    m_st = 3'b000; m_hd = 3'd0; m_tl = 3'd0; m_cnt = 4'd0;
  endtask

  // Advance the reference model by one edge for the given requests.
  task automatic model_step(input logic w, input logic r);
    logic [2:0] nh, nt;
    logic [3:0] nc;
    nh = m_hd; nt = m_tl; nc = m_cnt;
    if (m_st == 3'b010) begin nt = m_tl + 3'd1; nc = m_cnt + 4'd1; end
    else if (m_st == 3'b100) begin nh = m_hd + 3'd1; nc = m_cnt - 4'd1; end
    else if (m_st == 3'b011) nc = 4'd8;
    else if (m_st == 3'b101) nc = 4'd0;
    if (w && !r)      m_st = (nc == 4'd8) ? 3'b011 : 3'b010;
    else if (r && !w) m_st = (nc == 4'd0) ? 3'b101 : 3'b100;
    else              m_st = 3'b001;
    m_hd = nh; m_tl = nt; m_cnt = nc;
  endtask

  // Called at a falling edge: drive, predict, clock, compare.
  task automatic step(input logic w, input logic r);
    exp_t e;
    wr_en = w;
    rd_en = r;
    model_step(w, r);
    sb_q.push_back({m_st, m_hd, m_tl, m_cnt});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      e = sb_q.pop_front();
      check_all(e);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all({m_st, m_hd, m_tl, m_cnt});
    reset_n = 1'b1;
  endtask

  initial begin
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_state", 32'(state), 32'd0);

    // reset then idle
    do_reset();
    step(1'b0, 1'b0);
    check("idle_state", 32'(state), 32'd1);

    // fill, overflow write, then drain and underflow read
    repeat (9) step(1'b1, 1'b0);
    check("ovf_err",   32'(wr_err), 32'd1);
    check("ovf_tail",  32'(tail),   32'd0);
    check("ovf_count", 32'(data_count), 32'd8);
    step(1'b0, 1'b0);
    repeat (9) step(1'b0, 1'b1);
    check("unf_err",  32'(rd_err), 32'd1);
    check("unf_head", 32'(head),   32'd0);
    step(1'b0, 1'b0);
    check("drain_empty", 32'(empty), 32'd1);

    // simultaneous requests at count 3
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("simul_count", 32'(data_count), 32'd3);
    check("simul_state", 32'(state), 32'd1);

    // wrap-around from a fresh reset
    do_reset();
    repeat (5) step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b1);
    repeat (6) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("wrap_tail",  32'(tail),       32'd3);
    check("wrap_head",  32'(head),       32'd5);
    check("wrap_count", 32'(data_count), 32'd6);

    // mid-operation asynchronous reset, between edges
    do_reset();
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("pre_rst_count", 32'(data_count), 32'd5);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all({m_st, m_hd, m_tl, m_cnt});
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b1);   // read from empty right after reset
    step(1'b0, 1'b0);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    if (sb_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fifo_ctrl_reg
`default_nettype wire
